uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive engine for the MiniUART peripheral. It samples the asynchronous `rxd` line, frames 8N1 characters using a programmable divisor, and hands completed bytes to the MiniUART register layer through a one-entry holding buffer. That layer owns `rx_ack` and reads the byte, error and overrun flags into its DATA/LSR registers. It is the stage directly upstream of the WISHBONE-facing register file.

## Interface
- `DIV_W`, default 16: width of the divisor input.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (acts when `rst==0` at a rising edge of `clk`).
- `divr`  in  DIV_W  clock cycles per bit, equal to fclk/baud. Values 0 and 1 are treated as 2. Sampled only in IDLE.
- `rxd`  in  1  serial input. Asynchronous; idles high.
- `rx_ack`  in  1  one-cycle pulse from the register layer; consumes the buffered byte.
- `rx_data`  out  8  last accepted byte, LSB received first.
- `rx_valid`  out  1  byte available; held until `rx_ack`.
- `rx_ferr`  out  1  framing error (stop bit sampled 0) for the byte in `rx_data`.
- `rx_ovr`  out  1  sticky overrun flag.
- `rx_busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Synchronizer: `rxd` passes through two flops to produce `rxs`. Its reset value is 1. All decisions use `rxs` only.
- FSM states: IDLE, START, DATA, STOP, WAITHI.
- A single counter `cnt` (DIV_W bits) and a bit index `idx` (3 bits) drive the FSM.
- IDLE
  - `cnt=0`; latch the effective divisor `d`.
  - On `rxs==0`, go to START.
- START
  - Count until `cnt==(d>>1)-1`, then sample.
  - `rxs==1` is a glitch: go to IDLE with no output change.
  - `rxs==0`: go to DATA with `cnt=0` and `idx=0`.
- DATA
  - At `cnt==d-1`, shift `rxs` into bit `idx` of the shift register, set `cnt=0`, and increment `idx`.
  - After bit 7, go to STOP.
- STOP
  - At `cnt==d-1`, sample the stop bit and attempt a buffer load (rules below).
  - `rxs==1`: go to IDLE.
  - `rxs==0`: go to WAITHI.
- WAITHI
  - Wait for `rxs==1`, then go to IDLE.
  - This prevents a break condition from retriggering reception.
- Buffer load rules, applied on the stop-sample edge:
  - If `rx_valid==0`, or `rx_ack==1` on the same edge:
    - `rx_data` takes the shift register.
    - `rx_ferr` takes `~rxs`.
    - `rx_valid` is 1.
  - Otherwise the new byte is discarded, `rx_ovr` is set to 1, and `rx_data`/`rx_ferr` are unchanged.
- `rx_ack` without a load on the same edge:
  - `rx_valid`, `rx_ferr` and `rx_ovr` are cleared.
  - `rx_data` is retained.
- `rx_ack` together with a load: the load wins for valid/data/ferr, and `rx_ovr` is cleared.
- `rx_ack` while `rx_valid==0` has no effect.
- Reset values: `rx_data=0`, `rx_valid=0`, `rx_ferr=0`, `rx_ovr=0`, `rx_busy=0`, FSM state IDLE, `cnt=0`, `idx=0`, synchronizer flops 1.
- Reset mid-frame abandons the frame with no partial output. After reset, the FSM waits in IDLE for a fresh falling edge.

## Timing
- `rxd` to `rxs` latency: 2 cycles.
- The START sample occurs `d>>1` cycles after the first cycle IDLE sees `rxs==0`.
- Data bit k is sampled `(d>>1) + (k+1)·d` cycles after that point. The stop bit is sampled at `(d>>1) + 9·d`.
- `rx_valid` is seen high on the cycle after the stop-sample edge. End-to-end latency from the `rxd` fall is `2 + 1 + (d>>1) + 9·d` cycles, ±1.
- `rx_busy` rises the cycle after IDLE sees `rxs==0`. It falls the cycle after the STOP or WAITHI exit.
- Back-to-back frames: a new start bit arriving immediately after a valid stop bit is detected. IDLE occupies at most 1 cycle between frames.
- Outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- Reset with `rst=0` for 3 cycles, `divr=8`. Send `0x12` framed 8N1 at 8 cycles/bit. Expect `rx_data=0x12`, `rx_valid=1`, `rx_ferr=0`, `rx_ovr=0` within 2+1+4+72 (±1) cycles of the start edge. Pulse `rx_ack`; expect `rx_valid=0` on the next cycle.
- Glitch: drive `rxd` low for 2 cycles at `divr=8`. Expect `rx_busy` to pulse, then `rx_valid` to stay 0. Then send `0x5A`; expect `rx_data=0x5A`.
- Framing error: send `0xA5` with the stop bit driven 0 and held low 20 cycles. Expect `rx_data=0xA5` and `rx_ferr=1`. `rx_busy` stays 1 until 2 cycles after `rxd` returns high.
- Overrun: send `0x11` then `0x22` with no ack. Expect `rx_data=0x11` and `rx_ovr=1` after the second stop. After ack, expect `rx_ovr=0` and `rx_valid=0`.
- Simultaneous ack and load: send `0x33`, then send `0x44` and assert `rx_ack` on the exact stop-sample edge of `0x44`. Expect `rx_data=0x44`, `rx_valid=1`, `rx_ovr=0`.
- Reset mid-frame: assert `rst=0` for one cycle during data bit 3 of `0x7E`. Expect all outputs at their reset values and no byte delivered. Then send `0x81`; expect `rx_data=0x81`.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver with a programmable divisor and a one-entry holding buffer.
// Delivers each byte with framing-error and sticky-overrun status to the register layer.
module uart_rx_core #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divr,
  input  logic             rxd,
  input  logic             rx_ack,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_ferr,
  output logic             rx_ovr,
  output logic             rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  state_t           state;
  state_t           state_nx;
  logic             sync1;
  logic             rxs;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] half_m1;
  logic [DIV_W-1:0] bit_m1;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             start_hit;
  logic             bit_hit;
  logic             data_sample;
  logic             stop_sample;
  logic             load_ok;

  assign d_eff     = (divr < DIV_W'(2)) ? DIV_W'(2) : divr;
  assign half_m1   = (d >> 1) - DIV_W'(1);
  assign bit_m1    = d - DIV_W'(1);
  assign start_hit = (cnt == half_m1);
  assign bit_hit   = (cnt == bit_m1);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rxs) state_nx = START;
      START:   if (start_hit) state_nx = rxs ? IDLE : DATA;
      DATA:    if (bit_hit && idx == 3'd7) state_nx = STOP;
      STOP:    if (bit_hit) state_nx = rxs ? IDLE : WAITHI;
      WAITHI:  if (rxs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_busy     = (state != IDLE);
    data_sample = (state == DATA) && bit_hit;
    stop_sample = (state == STOP) && bit_hit;
  end

  // Bit timing: cnt restarts at every sample point; the divisor is frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= '0;
      d     <= DIV_W'(2);
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          d   <= d_eff;
        end
        START: begin
          cnt <= start_hit ? '0 : cnt + DIV_W'(1);
          idx <= '0;
        end
        DATA: begin
          if (data_sample) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            idx        <= idx + 3'd1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOP:    cnt <= bit_hit ? '0 : cnt + DIV_W'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // rx_valid rises on a load and holds until an rx_ack pulse; an ack with nothing
  // pending is ignored, and an ack coinciding with a load lets the new byte through.
  assign load_ok = !rx_valid || rx_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end else if (stop_sample) begin
      if (load_ok) begin
        rx_data  <= shreg;
        rx_ferr  <= ~rxs;
        rx_valid <= 1'b1;
        if (rx_ack) rx_ovr <= 1'b0;
      end else begin
        rx_ovr <= 1'b1;
      end
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a table of 8N1 frames at several divisors,
// then hand-written glitch, framing, overrun, ack/load collision and mid-frame reset sequences.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divr;
  logic        rxd;
  logic        rx_ack;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  logic        rx_ovr;
  logic        rx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frame_c0 = 0;
  int rise_cyc = -1;
  logic valid_q = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         divr;
    int         bitlen;
    logic [7:0] exp_data;
    logic       exp_ferr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  uart_rx_core #(.DIV_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .divr     (divr),
    .rxd      (rxd),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_ovr   (rx_ovr),
    .rx_busy  (rx_busy)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int act, input int exp);
    n_cmp++;
    if (act < exp - 1 || act > exp + 1) begin
      n_err++;
      $display("FAIL %s: got %0d cycles expected %0d +/-1", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic run_frame(input logic [7:0] b, input logic stop_bit, input int bl,
                           input int stop_len, input int ack_at, input int abort_at);
    int total;
    int j;
    total    = 9 * bl + stop_len;
    frame_c0 = cyc;
    for (int c = 0; c < total; c++) begin
      if (abort_at >= 0 && c >= abort_at) break;
      j = c / bl;
      if (j == 0)      rxd = 1'b0;
      else if (j <= 8) rxd = b[j-1];
      else             rxd = stop_bit;
      rx_ack = (c == ack_at);
      @(negedge clk);
    end
    rxd    = 1'b1;
    rx_ack = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !rx_valid; i++) @(negedge clk);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic saw_busy;

    vecs[0] = '{8'h12, 1'b1, 8,  8,  8'h12, 1'b0, 79};
    vecs[1] = '{8'h00, 1'b1, 8,  8,  8'h00, 1'b0, 79};
    vecs[2] = '{8'hFF, 1'b1, 3,  3,  8'hFF, 1'b0, 31};
    vecs[3] = '{8'hC3, 1'b1, 1,  2,  8'hC3, 1'b0, 22};
    vecs[4] = '{8'h3C, 1'b1, 0,  2,  8'h3C, 1'b0, 22};
    vecs[5] = '{8'h96, 1'b1, 16, 16, 8'h96, 1'b0, 155};
    vecs[6] = '{8'h5A, 1'b1, 2,  2,  8'h5A, 1'b0, 22};
    vecs[7] = '{8'hE7, 1'b0, 5,  5,  8'hE7, 1'b1, 50};

    rst    = 1'b0;
    rxd    = 1'b1;
    rx_ack = 1'b0;
    divr   = 16'd8;
    repeat (3) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_ferr", rx_ferr, 1'b0);
    check("reset rx_ovr", rx_ovr, 1'b0);
    check("reset rx_busy", rx_busy, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      divr = 16'(vecs[v].divr);
      repeat (3) @(negedge clk);
      rise_cyc = -1;
      run_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].bitlen, vecs[v].bitlen, -1, -1);
      wait_valid(4 * vecs[v].bitlen + 10);
      @(negedge clk);
      check("table rx_valid", rx_valid, 1'b1);
      check("table rx_data", rx_data, vecs[v].exp_data);
      check("table rx_ferr", rx_ferr, vecs[v].exp_ferr);
      check("table rx_ovr", rx_ovr, 1'b0);
      check_lat("table latency", rise_cyc - frame_c0, vecs[v].exp_lat);
      pulse_ack();
      check("table ack rx_valid", rx_valid, 1'b0);
      check("table ack rx_ferr", rx_ferr, 1'b0);
      check("table ack keeps rx_data", rx_data, vecs[v].exp_data);
      repeat (6) @(negedge clk);
      check("table idle rx_busy", rx_busy, 1'b0);
    end

    // ack with nothing pending
    pulse_ack();
    check("stray ack rx_valid", rx_valid, 1'b0);
    check("stray ack rx_ovr", rx_ovr, 1'b0);

    divr = 16'd8;
    repeat (3) @(negedge clk);

    // glitch: 2-cycle low pulse must be rejected at the START sample
    saw_busy = 1'b0;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | rx_busy;
    end
    check("glitch busy pulse", saw_busy, 1'b1);
    check("glitch busy back low", rx_busy, 1'b0);
    check("glitch rx_valid", rx_valid, 1'b0);
    run_frame(8'h5A, 1'b1, 8, 8, -1, -1);
    wait_valid(40);
    check("after glitch rx_data", rx_data, 8'h5A);
    check("after glitch rx_valid", rx_valid, 1'b1);
    pulse_ack();
    repeat (4) @(negedge clk);

    // framing error with a 20-cycle low stop; busy holds through WAITHI
    run_frame(8'hA5, 1'b0, 8, 20, -1, -1);
    check("ferr rx_data", rx_data, 8'hA5);
    check("ferr rx_ferr", rx_ferr, 1'b1);
    check("ferr rx_valid", rx_valid, 1'b1);
    check("ferr busy in waithi", rx_busy, 1'b1);
    repeat (2) @(negedge clk);
    check("ferr busy +2", rx_busy, 1'b1);
    @(negedge clk);
    check("ferr busy +3", rx_busy, 1'b0);
    pulse_ack();
    check("ferr ack rx_ferr", rx_ferr, 1'b0);
    repeat (4) @(negedge clk);

    // overrun: two back-to-back frames, no ack
    run_frame(8'h11, 1'b1, 8, 8, -1, -1);
    run_frame(8'h22, 1'b1, 8, 8, -1, -1);
    repeat (6) @(negedge clk);
    check("ovr rx_data", rx_data, 8'h11);
    check("ovr rx_valid", rx_valid, 1'b1);
    check("ovr rx_ovr", rx_ovr, 1'b1);
    pulse_ack();
    check("ovr ack rx_ovr", rx_ovr, 1'b0);
    check("ovr ack rx_valid", rx_valid, 1'b0);
    repeat (4) @(negedge clk);

    // ack exactly on the stop-sample edge of a frame while an overrun is pending
    run_frame(8'h33, 1'b1, 8, 8, -1, -1);
    run_frame(8'h55, 1'b1, 8, 8, -1, -1);
    repeat (4) @(negedge clk);
    check("collide pre rx_ovr", rx_ovr, 1'b1);
    check("collide pre rx_data", rx_data, 8'h33);
    run_frame(8'h44, 1'b1, 8, 8, 2 + 4 + 72, -1);
    check("collide rx_data", rx_data, 8'h44);
    check("collide rx_valid", rx_valid, 1'b1);
    check("collide rx_ovr", rx_ovr, 1'b0);
    check("collide rx_ferr", rx_ferr, 1'b0);
    repeat (4) @(negedge clk);
    run_frame(8'h66, 1'b1, 8, 8, -1, -1);
    repeat (4) @(negedge clk);
    check("second ovr rx_ovr", rx_ovr, 1'b1);
    check("second ovr rx_data", rx_data, 8'h44);

    // reset during data bit 3 of 0x7E
    run_frame(8'h7E, 1'b1, 8, 8, -1, 35);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midreset rx_data", rx_data, 8'h00);
    check("midreset rx_valid", rx_valid, 1'b0);
    check("midreset rx_ferr", rx_ferr, 1'b0);
    check("midreset rx_ovr", rx_ovr, 1'b0);
    check("midreset rx_busy", rx_busy, 1'b0);
    repeat (100) @(negedge clk);
    check("midreset no byte", rx_valid, 1'b0);
    check("midreset stays idle", rx_busy, 1'b0);
    run_frame(8'h81, 1'b1, 8, 8, -1, -1);
    wait_valid(40);
    check("after reset rx_data", rx_data, 8'h81);
    check("after reset rx_valid", rx_valid, 1'b1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
